// File: rtl/tau_pkg.sv
// Shared fetch-path definitions: PC control codes, fetch FSM states
// and a few opcode constants used by downstream decode and benches.
package tau_pkg;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;

    localparam int BYTES_PER_INSTR = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch from flash into little-endian 32-bit
// words, stepping the PC once per captured byte.
module instr_fetch_unit
    import tau_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int READ_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [1:0]        pc_control,
    output logic              flash_re,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic [7:0]        flash_out,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy
);

    localparam logic [3:0] LAT      = 4'(READ_LATENCY);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_INSTR - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       instr_q, instr_d;

    // State and datapath registers; reset returns everything to zero/IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    // Next state, byte capture and handshake; flush overrides all of it.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        pc_control  = PC_HOLD;
        flash_re    = 1'b0;
        instr_valid = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fetch_start) begin
                        base_d  = pc_in;
                        addr_d  = pc_in;
                        idx_d   = '0;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    flash_re = 1'b1;
                    cnt_d    = LAT;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    flash_re = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pc_control = PC_INC;
                        instr_d[{idx_q, 3'b000} +: 8] = flash_out;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = base_q + ADDR_W'(idx_d);
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    instr_valid = 1'b1;
                    if (instr_ready) begin
                        if (fetch_start) begin
                            base_d  = pc_in;
                            addr_d  = pc_in;
                            idx_d   = '0;
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign flash_addr = addr_q;
    assign instr      = instr_q;
    assign instr_pc   = base_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-accurate flash model, PC model,
// directed scenarios plus randomized fetches against a word-level model.
module tb_instr_fetch_unit;
    import tau_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [23:0] pc_in;
    logic [1:0]  pc_control;
    logic        flash_re;
    logic [23:0] flash_addr;
    logic [7:0]  flash_out;
    logic        flush;
    logic [31:0] instr;
    logic [23:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;

    logic        reset1;
    logic        start1;
    logic [23:0] pc_in1;
    logic [1:0]  pc_control1;
    logic        flash_re1;
    logic [23:0] flash_addr1;
    logic [7:0]  flash_out1;
    logic [31:0] instr1;
    logic [23:0] instr_pc1;
    logic        valid1;
    logic        ready1;
    logic        busy1;

    logic [7:0]  mem [0:4095];
    logic [23:0] pc0, pc1;
    int          pulses0, pulses1;
    int          tests, fails;

    int          scnt0, scnt1;
    logic        lre0, lre1;
    logic [23:0] laddr0, laddr1;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(24), .READ_LATENCY(3)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start),
        .pc_in(pc_in), .pc_control(pc_control), .flash_re(flash_re),
        .flash_addr(flash_addr), .flash_out(flash_out), .flush(flush),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy)
    );

    instr_fetch_unit #(.ADDR_W(24), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset1), .fetch_start(start1),
        .pc_in(pc_in1), .pc_control(pc_control1), .flash_re(flash_re1),
        .flash_addr(flash_addr1), .flash_out(flash_out1), .flush(1'b0),
        .instr(instr1), .instr_pc(instr_pc1), .instr_valid(valid1),
        .instr_ready(ready1), .busy(busy1)
    );

    // Flash data is only valid once address and enable have been stable
    // for the configured latency; before that the bus shows junk.
    always @(posedge clk) begin
        if (flash_re)
            scnt0 <= (lre0 && flash_addr == laddr0) ? scnt0 + 1 : 1;
        else
            scnt0 <= 0;
        lre0   <= flash_re;
        laddr0 <= flash_addr;
        if (flash_re1)
            scnt1 <= (lre1 && flash_addr1 == laddr1) ? scnt1 + 1 : 1;
        else
            scnt1 <= 0;
        lre1   <= flash_re1;
        laddr1 <= flash_addr1;
    end

    always_comb begin
        flash_out = 8'hEE;
        if (scnt0 >= 3) flash_out = mem[flash_addr[11:0]];
    end

    always_comb begin
        flash_out1 = 8'hEE;
        if (scnt1 >= 1) flash_out1 = mem[flash_addr1[11:0]];
    end

    function automatic logic [7:0] rd(input logic [23:0] a);
        return mem[a[11:0]];
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {rd(a + 24'd3), rd(a + 24'd2), rd(a + 24'd1), rd(a)};
    endfunction

    task automatic poke_word(input logic [23:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [23:0] x;
            x = a + 24'(i);
            mem[x[11:0]] = w[8*i +: 8];
        end
    endtask

    // One clock: the PC models step on pulses seen before the edge.
    task automatic tick();
        logic inc0, inc1;
        inc0 = (pc_control == PC_INC);
        inc1 = (pc_control1 == PC_INC);
        @(posedge clk);
        #1;
        if (inc0) begin
            pc0 = pc0 + 24'd1;
            pulses0++;
        end
        if (inc1) begin
            pc1 = pc1 + 24'd1;
            pulses1++;
        end
        pc_in  = pc0;
        pc_in1 = pc1;
    endtask

    // Stimulus only: start a fetch, wait for valid, stall, then accept.
    task automatic run_fetch(input logic [23:0] b, input int stall,
                             output logic [31:0] gi,
                             output logic [23:0] gp,
                             output int lat, output int np);
        int p0;
        pc0 = b;
        pc_in = b;
        p0 = pulses0;
        fetch_start = 1'b1;
        instr_ready = (stall == 0);
        tick();
        fetch_start = 1'b0;
        lat = 0;
        while (!instr_valid && lat < 200) begin
            tick();
            lat++;
        end
        gi = instr;
        gp = instr_pc;
        for (int i = 0; i < stall; i++) tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        np = pulses0 - p0;
    endtask

    task automatic test_reset();
        tests++;
        if (pc_control !== PC_HOLD) begin
            fails++;
            $display("FAIL reset_pc_control got %b want 00", pc_control);
        end
        tests++;
        if (flash_re !== 1'b0 || flash_addr !== 24'h0) begin
            fails++;
            $display("FAIL reset_flash got re=%b addr=%h want 0/0",
                     flash_re, flash_addr);
        end
        tests++;
        if (instr !== 32'h0 || instr_pc !== 24'h0) begin
            fails++;
            $display("FAIL reset_instr got %h/%h want 0/0", instr, instr_pc);
        end
        tests++;
        if (instr_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_status got valid=%b busy=%b want 0/0",
                     instr_valid, busy);
        end
    endtask

    task automatic test_single();
        logic [31:0] gi;
        logic [23:0] gp;
        int lat, np;
        poke_word(24'h0, 32'h02000283);
        run_fetch(24'h0, 0, gi, gp, lat, np);
        tests++;
        if (gi !== 32'h02000283) begin
            fails++;
            $display("FAIL single_instr got %h want 02000283", gi);
        end
        tests++;
        if (gp !== 24'h0) begin
            fails++;
            $display("FAIL single_pc got %h want 000000", gp);
        end
        tests++;
        if (lat != 16) begin
            fails++;
            $display("FAIL single_latency got %0d want 16", lat);
        end
        tests++;
        if (np != 4 || pc0 !== 24'd4) begin
            fails++;
            $display("FAIL single_pulses got %0d pc=%h want 4 pc=000004",
                     np, pc0);
        end
        tests++;
        if (instr_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_after got valid=%b busy=%b want 0/0",
                     instr_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] gi [4];
        logic [23:0] gp [4];
        int t [4];
        int n, got, p0;
        logic idle_seen;
        poke_word(24'h0, 32'h02000283);
        poke_word(24'h4, 32'h02100303);
        poke_word(24'h8, 32'h006283b3);
        poke_word(24'hC, 32'h02700123);
        pc0 = 24'h0;
        pc_in = pc0;
        p0 = pulses0;
        fetch_start = 1'b1;
        instr_ready = 1'b1;
        tick();
        n = 0;
        got = 0;
        idle_seen = 1'b0;
        while (got < 4 && n < 400) begin
            if (!busy) idle_seen = 1'b1;
            if (instr_valid) begin
                gi[got] = instr;
                gp[got] = instr_pc;
                t[got] = n;
                got++;
                if (got == 4) fetch_start = 1'b0;
            end
            tick();
            n++;
        end
        instr_ready = 1'b0;
        fetch_start = 1'b0;
        tests++;
        if (got != 4) begin
            fails++;
            $display("FAIL b2b_count got %0d want 4", got);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (gi[i] !== exp_word(24'(4*i)) || gp[i] !== 24'(4*i)
                    || t[i] != 16 + 17*i) begin
                    fails++;
                    $display("FAIL b2b_%0d got %h@%h t=%0d want %h@%h t=%0d",
                             i, gi[i], gp[i], t[i], exp_word(24'(4*i)),
                             24'(4*i), 16 + 17*i);
                end
            end
        end
        tests++;
        if (idle_seen || pulses0 - p0 != 16) begin
            fails++;
            $display("FAIL b2b_flow got idle=%b pulses=%0d want 0/16",
                     idle_seen, pulses0 - p0);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end got busy=%b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w, hold_i;
        logic [23:0] hold_p;
        int n, p0, bad;
        w = $urandom;
        poke_word(24'h20, w);
        pc0 = 24'h20;
        pc_in = pc0;
        fetch_start = 1'b1;
        instr_ready = 1'b0;
        tick();
        fetch_start = 1'b0;
        n = 0;
        while (!instr_valid && n < 200) begin
            tick();
            n++;
        end
        hold_i = instr;
        hold_p = instr_pc;
        p0 = pulses0;
        bad = 0;
        fetch_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr !== hold_i || instr_pc !== hold_p || flash_re !== 1'b0
                || instr_valid !== 1'b1)
                bad++;
        end
        tests++;
        if (hold_i !== w || hold_p !== 24'h20) begin
            fails++;
            $display("FAIL bp_data got %h@%h want %h@000020",
                     hold_i, hold_p, w);
        end
        tests++;
        if (bad != 0 || pulses0 != p0) begin
            fails++;
            $display("FAIL bp_stall got %0d bad cycles %0d pulses want 0/0",
                     bad, pulses0 - p0);
        end
        fetch_start = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release got valid=%b busy=%b want 0/0",
                     instr_valid, busy);
        end
    endtask

    task automatic test_flush();
        logic [31:0] gi;
        logic [23:0] gp;
        int lat, np, n, p0, rose;
        pc0 = 24'h0;
        pc_in = pc0;
        p0 = pulses0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n = 0;
        while (pulses0 - p0 < 2 && n < 200) begin
            tick();
            n++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++;
        if (busy !== 1'b0 || instr_valid !== 1'b0 || flash_re !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle got busy=%b valid=%b re=%b want 0/0/0",
                     busy, instr_valid, flash_re);
        end
        rose = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_valid) rose++;
        end
        tests++;
        if (rose != 0 || pulses0 - p0 != 2) begin
            fails++;
            $display("FAIL flush_pulses got valid=%0d pulses=%0d want 0/2",
                     rose, pulses0 - p0);
        end
        flush = 1'b1;
        fetch_start = 1'b1;
        tick();
        flush = 1'b0;
        fetch_start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop_start got busy=%b want 0", busy);
        end
        run_fetch(24'h8, 0, gi, gp, lat, np);
        tests++;
        if (gi !== 32'h006283b3 || gp !== 24'h8 || lat != 16) begin
            fails++;
            $display("FAIL flush_refetch got %h@%h lat=%0d want 006283b3@8 16",
                     gi, gp, lat);
        end
    endtask

    task automatic test_reset_mid();
        int n, p0;
        poke_word(24'h40, $urandom);
        pc0 = 24'h40;
        pc_in = pc0;
        p0 = pulses0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n = 0;
        while (pulses0 - p0 < 1 && n < 200) begin
            tick();
            n++;
        end
        tick();
        reset = 1'b1;
        tick();
        tests++;
        if (pc_control !== PC_HOLD || flash_re !== 1'b0
            || flash_addr !== 24'h0 || instr !== 32'h0
            || instr_pc !== 24'h0 || instr_valid !== 1'b0
            || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid got pc=%b re=%b a=%h i=%h ip=%h v=%b b=%b want zeros",
                     pc_control, flash_re, flash_addr, instr, instr_pc,
                     instr_valid, busy);
        end
        reset = 1'b0;
        p0 = pulses0;
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if (pulses0 != p0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_quiet got pulses=%0d busy=%b want 0/0",
                     pulses0 - p0, busy);
        end
    endtask

    task automatic test_latency1();
        int n, p0;
        poke_word(24'h0, 32'h02000283);
        reset1 = 1'b0;
        tick();
        pc1 = 24'h0;
        pc_in1 = pc1;
        p0 = pulses1;
        start1 = 1'b1;
        ready1 = 1'b0;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!valid1 && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (n != 8 || instr1 !== 32'h02000283 || instr_pc1 !== 24'h0) begin
            fails++;
            $display("FAIL lat1 got %h@%h lat=%0d want 02000283@0 8",
                     instr1, instr_pc1, n);
        end
        tests++;
        if (pulses1 - p0 != 4) begin
            fails++;
            $display("FAIL lat1_pulses got %0d want 4", pulses1 - p0);
        end
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        reset1 = 1'b1;
    endtask

    task automatic test_wrap();
        logic [23:0] q [$];
        logic [23:0] b;
        int n;
        b = 24'hFFFFFE;
        for (int i = 0; i < 4; i++) begin
            logic [23:0] x;
            x = b + 24'(i);
            mem[x[11:0]] = 8'($urandom);
        end
        pc0 = b;
        pc_in = pc0;
        fetch_start = 1'b1;
        instr_ready = 1'b0;
        tick();
        fetch_start = 1'b0;
        n = 0;
        while (!instr_valid && n < 200) begin
            if (flash_re && (q.size() == 0 || q[$] !== flash_addr))
                q.push_back(flash_addr);
            tick();
            n++;
        end
        tests++;
        if (q.size() != 4) begin
            fails++;
            $display("FAIL wrap_count got %0d want 4", q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q[i] !== b + 24'(i)) begin
                    fails++;
                    $display("FAIL wrap_addr%0d got %h want %h",
                             i, q[i], b + 24'(i));
                end
            end
        end
        tests++;
        if (instr !== exp_word(b) || instr_pc !== b || pc0 !== 24'h000002) begin
            fails++;
            $display("FAIL wrap_instr got %h@%h pc=%h want %h@%h pc=000002",
                     instr, instr_pc, pc0, exp_word(b), b);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] gi;
        logic [23:0] gp, b;
        int lat, np, st;
        for (int k = 0; k < 20; k++) begin
            b = 24'($urandom);
            poke_word(b, $urandom);
            st = $urandom_range(0, 3);
            run_fetch(b, st, gi, gp, lat, np);
            tests++;
            if (gi !== exp_word(b) || gp !== b || lat != 16 || np != 4
                || pc0 !== b + 24'd4) begin
                fails++;
                $display("FAIL rand_%0d got %h@%h lat=%0d np=%0d want %h@%h 16 4",
                         k, gi, gp, lat, np, exp_word(b), b);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        tests = 0;
        fails = 0;
        pulses0 = 0;
        pulses1 = 0;
        pc0 = '0;
        pc1 = '0;
        pc_in = '0;
        pc_in1 = '0;
        reset = 1'b1;
        reset1 = 1'b1;
        fetch_start = 1'b0;
        start1 = 1'b0;
        flush = 1'b0;
        instr_ready = 1'b0;
        ready1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_latency1();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequences instruction fetch from the byte-wide flash and assembles little-endian 32-bit instructions.
- Drives the program counter's increment control and hands completed instructions to the control unit over a valid/ready handshake.
- Sits between flash and program_counter (upstream) and control_unit (downstream).
- Replaces hand-sequenced fetch in benches and top-level glue.

Parameters:
- ADDR_W, 24, flash byte-address width; matches pc_out width.
- READ_LATENCY, 3, cycles from flash_addr/flash_re held stable to flash_out valid; legal range 1..15.
- BYTES_PER_INSTR, 4, fixed; not overridable.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_start  input  1  request one instruction fetch, starting at pc_in.
- pc_in  input  ADDR_W  current PC (program_counter pc_out), sampled when a fetch is accepted.
- pc_control  output  2  to program_counter: 2'b00 hold, 2'b01 increment.
- flash_re  output  1  flash read enable.
- flash_addr  output  ADDR_W  flash byte address.
- flash_out  input  8  flash read data.
- flush  input  1  abort any fetch in progress and discard the held instruction.
- instr  output  32  assembled instruction.
- instr_pc  output  ADDR_W  address of the instruction's first byte.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  consumer accepts instr this cycle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock port is clk; reset port is reset; one clock domain; reset is synchronous and active-high.
- Reset values:
  - State: IDLE.
  - pc_control=2'b00, flash_re=0, flash_addr=0.
  - instr=0, instr_pc=0, instr_valid=0, busy=0.
  - Internal byte_idx=0, wait counter=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On fetch_start=1 (and flush=0): capture base=pc_in, set byte_idx=0, go to REQ.
- REQ (1 cycle):
  - flash_re=1, flash_addr=(base+byte_idx) mod 2^ADDR_W.
  - Load wait counter with READ_LATENCY, go to WAIT.
- WAIT:
  - flash_re and flash_addr held stable; counter decrements each cycle.
  - In the cycle the counter reaches 1, flash_out is captured at that edge into instr[8*byte_idx+7 : 8*byte_idx].
  - pc_control=2'b01 for exactly that one cycle; otherwise pc_control=2'b00.
  - Then byte_idx increments; if byte_idx was 3, go to DONE, else go to REQ.
- Per byte: 1+READ_LATENCY cycles. Per instruction: 4*(1+READ_LATENCY) cycles from the start-accept edge to DONE entry (16 at default).
- Exactly 4 increment pulses are issued per completed fetch, so pc_out=base+4 on completion.
- flash_re is 0 in IDLE and DONE; flash_addr holds its last value. Bytes already captured are not re-read.
- DONE:
  - instr_valid=1, instr_pc=base; instr and instr_pc stable until the handshake.
  - Handshake when instr_valid & instr_ready.
  - On handshake with fetch_start=1: capture new base=pc_in and go directly to REQ (back-to-back, no IDLE bubble). Otherwise go to IDLE.
  - instr_valid drops the cycle after the handshake.
- fetch_start is ignored in REQ and WAIT, and in DONE without instr_ready.
- flush (priority over everything except reset):
  - Next state IDLE; instr_valid=0; flash_re=0; pc_control=2'b00 that cycle.
  - PC increments already issued are not undone; the owner of the PC reloads it.
  - flush together with fetch_start in the same cycle: the start is dropped.
- Address wrap: base+byte_idx wraps modulo 2^ADDR_W (e.g. 0xFFFFFE..0x000001).
- Reset mid-fetch: immediate return to reset values at that edge; no further pc_control pulse.
- The unit never writes flash. An external mux gives this unit the flash port whenever busy=1; the data-side load/store owns it otherwise.

Decomposition:
- Shared package tau_pkg holds:
  - PC_HOLD=2'b00 and PC_INC=2'b01.
  - Fetch state enum.
  - Opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_OP=7'b0110011, for downstream users and benches.
- No sub-module required; the latency counter and byte assembly live inline.

Test Plan:
- Single fetch:
  - Stimulus: flash[0..3]=83 02 00 02, pc_in=0, fetch_start pulse, instr_ready=1.
  - Required: instr=0x02000283, instr_pc=0; instr_valid 16 cycles after the accept edge; exactly 4 pc_control=01 pulses; pc_out=4 after completion.
- Back-to-back fetch:
  - Stimulus: instructions 0x02000283 @0, 0x02100303 @4, 0x006283b3 @8, 0x02700123 @0xC; fetch_start held high; instr_ready held high.
  - Required: four instructions in order with instr_pc 0,4,8,C; no IDLE cycle between them; 16 pc_control pulses total.
- Backpressure:
  - Stimulus: instr_ready=0 for 10 cycles after instr_valid.
  - Required: instr/instr_pc stable; flash_re=0; no pc_control pulse; handshake completes on the first ready cycle.
- Flush mid-fetch:
  - Stimulus: flush asserted after 2 bytes have been captured.
  - Required: IDLE next cycle; busy=0; instr_valid never rises; exactly 2 pulses issued. A new fetch at pc_in=8 then returns 0x006283b3.
- Reset mid-operation and latency:
  - Stimulus: reset during WAIT of byte 1; separately, READ_LATENCY=1.
  - Required: all outputs at reset values on the next edge. With READ_LATENCY=1, instr_valid arrives 8 cycles after accept, with identical data.
- Address wrap:
  - Stimulus: pc_in=0xFFFFFE.
  - Required: flash_addr sequence FFFFFE, FFFFFF, 000000, 000001; instr_pc=0xFFFFFE.
